// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request load/store sequencer between a core and a
// word-addressed data memory with fixed read latency.
// Optional feature: define MEM_ACCESS_BOUNDS_CHECK_EN to fault accesses whose
// effective address lies beyond the 2**ADDR_W-word memory instead of wrapping.
module mem_access_unit #(
   parameter int ADDR_W   = 10,
   parameter int READ_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_offset,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic        mem_memWrite,
   input  logic [31:0] mem_readData
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ_WAIT,
      RESP
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(READ_LAT - 1);

   state_t      state_reg;
   state_t      state_next;
   logic [3:0]  cnt_reg;
   logic [31:0] ea_reg;
   logic [31:0] wdata_reg;
   logic [31:0] rdata_reg;

   logic [31:0] ea;
   logic [31:0] lo_mask;
   logic [31:0] ea_trunc;
   logic        fault;
   logic        accept;

   // Effective address wraps naturally modulo 2**32.
   assign ea = req_addr + req_offset;

   // Mask selecting the address bits that exist in the attached memory.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_mask
         assign lo_mask[gi] = (gi < ADDR_W);
      end
   endgenerate

   assign ea_trunc = ea & lo_mask;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   logic fault_reg;
   // Any set bit above the memory depth means the access is out of range.
   assign fault      = |(ea & ~lo_mask);
   assign resp_fault = fault_reg;
`else
   // Out-of-range addresses simply alias onto the low memory words.
   assign fault      = 1'b0;
   assign resp_fault = 1'b0;
`endif

   assign accept        = req_valid && req_ready;
   assign mem_address   = ea_reg;
   assign mem_writeData = wdata_reg;
   assign resp_rdata    = rdata_reg;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and strobe decode; strobes are gated by rst_n so an aborted
   // access never writes memory or reports completion in the reset cycle.
   always_comb begin
      state_next   = state_reg;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      mem_memWrite = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid && rst_n) begin
               if (fault) begin
                  state_next = RESP;
               end else if (req_write) begin
                  state_next = WRITE;
               end else begin
                  state_next = READ_WAIT;
               end
            end
         end
         WRITE: begin
            mem_memWrite = rst_n;
            state_next   = RESP;
         end
         READ_WAIT: begin
            if (cnt_reg == LAST_CNT) begin
               state_next = RESP;
            end
         end
         RESP: begin
            resp_valid = rst_n;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request latching, read-latency counting and response data capture.
   // resp_rdata only changes on the edge that enters RESP so it holds steady
   // between responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         ea_reg    <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  ea_reg    <= ea_trunc;
                  wdata_reg <= req_wdata;
                  cnt_reg   <= '0;
                  if (fault) begin
                     rdata_reg <= '0;
                  end
               end
            end
            WRITE: begin
               rdata_reg <= '0;
            end
            READ_WAIT: begin
               if (cnt_reg == LAST_CNT) begin
                  rdata_reg <= mem_readData;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   // Fault flag is captured with the request and reported with its response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_reg <= 1'b0;
      end else if (accept) begin
         fault_reg <= fault;
      end
   end
`endif

endmodule
